// File: rtl/mem_write_buffer_if.sv
// mem_write_buffer_if: cpu-side and memory-side signals of the posted-write buffer
interface mem_write_buffer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              cpu_wr_req;
  logic [ADDR_W-1:0] cpu_wr_addr;
  logic [DATA_W-1:0] cpu_wr_data;
  logic              cpu_wr_ready;
  logic              cpu_rd_req;
  logic [ADDR_W-1:0] cpu_rd_addr;
  logic              cpu_rd_ready;
  logic [DATA_W-1:0] cpu_rd_data;
  logic              cpu_rd_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_memread;
  logic              mem_memwrite;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  modport slave (
    input  cpu_wr_req, cpu_wr_addr, cpu_wr_data, cpu_rd_req, cpu_rd_addr, mem_rdata, mem_done,
    output cpu_wr_ready, cpu_rd_ready, cpu_rd_data, cpu_rd_done, mem_addr, mem_wdata, mem_memread, mem_memwrite
  );
  modport master (
    output cpu_wr_req, cpu_wr_addr, cpu_wr_data, cpu_rd_req, cpu_rd_addr, mem_rdata, mem_done,
    input  cpu_wr_ready, cpu_rd_ready, cpu_rd_data, cpu_rd_done, mem_addr, mem_wdata, mem_memread, mem_memwrite
  );
endinterface

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: coalescing posted-write FIFO in front of main memory, reads take priority over drains
module mem_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic clk,
  input  logic rst,
  mem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, co_idx;
  logic [PW:0] count;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q, rd_data_q, hit_data, fwd_data;
  logic wr_acc, rd_go, drain_go, issuing, pop, push_app, rd_hit, co_hit, wr_fwd, fwd_hit;
  assign bus.cpu_wr_ready = rst && count != (PW+1)'(DEPTH);
  assign wr_acc   = bus.cpu_wr_req && bus.cpu_wr_ready;
  assign rd_go    = state == IDLE && bus.cpu_rd_req;
  assign drain_go = state == IDLE && !bus.cpu_rd_req && count != '0;
  assign issuing  = state == WRITE || drain_go;
  assign pop      = state == WRITE;
  assign push_app = wr_acc && !co_hit;
  assign wr_fwd   = wr_acc && bus.cpu_wr_addr == bus.cpu_rd_addr;
  assign fwd_hit  = wr_fwd || rd_hit;
  assign fwd_data = wr_fwd ? bus.cpu_wr_data : hit_data;
  // Walk oldest to newest so the newest match wins; the head is skipped for coalescing while it is in flight.
  always_comb begin
    rd_hit = 1'b0;
    hit_data = '0;
    co_hit = 1'b0;
    co_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PW+1)'(i) < count && addr_q[head + PW'(i)] == bus.cpu_rd_addr) begin
        rd_hit = 1'b1;
        hit_data = data_q[head + PW'(i)];
      end
      if ((PW+1)'(i) < count && addr_q[head + PW'(i)] == bus.cpu_wr_addr && !(i == 0 && issuing)) begin
        co_hit = 1'b1;
        co_idx = head + PW'(i);
      end
    end
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = bus.cpu_rd_req ? (fwd_hit ? RESP : READ) : (count != '0 ? WRITE : IDLE);
    else if (state == READ)
      state_nx = bus.mem_done ? RESP : READ;
    else
      state_nx = IDLE;
    bus.cpu_rd_ready = rst && state == IDLE;
    bus.cpu_rd_done  = state == RESP;
    bus.mem_memread  = state == READ;
    bus.mem_memwrite = state == WRITE;
    bus.cpu_rd_data  = rd_data_q;
    bus.mem_addr     = mem_addr_q;
    bus.mem_wdata    = mem_wdata_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      head <= '0;
      tail <= '0;
      count <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_nx;
      if (push_app) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + (PW+1)'(push_app) - (PW+1)'(pop);
      if (rd_go && fwd_hit) rd_data_q <= fwd_data;
      if (rd_go && !fwd_hit) mem_addr_q <= bus.cpu_rd_addr;
      if (drain_go) begin
        mem_addr_q <= addr_q[head];
        mem_wdata_q <= data_q[head];
      end
      if (state == READ && bus.mem_done) rd_data_q <= bus.mem_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (push_app) begin
      addr_q[tail] <= bus.cpu_wr_addr;
      data_q[tail] <= bus.cpu_wr_data;
    end
    if (wr_acc && co_hit) data_q[co_idx] <= bus.cpu_wr_data;
  end
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb_mem_write_buffer: scoreboard bench with a wait-state memory model and a coherent reference memory
module tb_mem_write_buffer;
  typedef struct packed {logic [4:0] a; logic [15:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_write_buffer_if bus();
  mem_write_buffer dut (.clk(clk), .rst(rst), .bus(bus));
  ent_t exp_wr [$];
  logic [15:0] exp_rd [$];
  logic [15:0] ref_mem [32];
  logic [15:0] mem_model [32];
  ent_t mon_e;
  logic [15:0] mon_d;
  int n_tests = 0, n_fail = 0, n_memwrite = 0, n_memread = 0;
  int rd_cnt = 0, mem_wait = 0, acc_memwrites = 0, base = 0, base_rd = 0, st = 0;
  bit stall = 1'b0;
  logic prev_memread = 1'b0, md_before_done = 1'b0;
  logic [4:0] prev_addr = '0;

  function automatic logic [15:0] init_val(input int a);
    logic [4:0] x;
    x = 5'(a);
    return (a == 9) ? 16'h0908 : {x, 3'b000, ~x, 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  assign bus.mem_rdata = mem_model[bus.mem_addr];
  assign bus.mem_done  = bus.mem_memwrite | (bus.mem_memread & ~stall & (rd_cnt >= mem_wait));
  always @(posedge clk) rd_cnt <= bus.mem_memread ? rd_cnt + 1 : 0;

  always @(negedge clk) begin
    if (!rst) begin
      for (int a = 0; a < 32; a++) mem_model[a] = init_val(a);
      prev_memread = 1'b0;
    end else begin
      if (bus.mem_memwrite) begin
        n_memwrite++;
        mem_model[bus.mem_addr] = bus.mem_wdata;
        if (exp_wr.size() == 0) chk("unexpected_memwrite", 1, 0);
        else begin
          mon_e = exp_wr.pop_front();
          chk("drain_addr", 32'(bus.mem_addr), 32'(mon_e.a));
          chk("drain_data", 32'(bus.mem_wdata), 32'(mon_e.d));
        end
      end
      if (bus.mem_memread && !prev_memread) n_memread++;
      if (bus.mem_memread && prev_memread) chk("memread_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
      prev_memread = bus.mem_memread;
      prev_addr = bus.mem_addr;
      if (bus.cpu_rd_done) begin
        if (exp_rd.size() == 0) chk("unexpected_rd_done", 1, 0);
        else begin
          mon_d = exp_rd.pop_front();
          chk("rd_data", 32'(bus.cpu_rd_data), 32'(mon_d));
        end
      end
    end
  end

  task automatic model_write(input logic [4:0] a, input logic [15:0] d);
    bit found;
    found = 1'b0;
    ref_mem[a] = d;
    foreach (exp_wr[i]) if (exp_wr[i].a == a) begin
      exp_wr[i] = {a, d};
      found = 1'b1;
    end
    if (!found) exp_wr.push_back({a, d});
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    bus.cpu_wr_req = 1'b1;
    bus.cpu_wr_addr = a;
    bus.cpu_wr_data = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      ok = bus.cpu_wr_ready;
      @(posedge clk);
      if (ok) begin
        model_write(a, d);
        acc_memwrites = n_memwrite;
      end
      @(negedge clk);
    end
    bus.cpu_wr_req = 1'b0;
    if (!ok) chk("wr_accept_timeout", 0, 1);
  endtask

  task automatic wait_rd_ready(output bit ok);
    for (int t = 0; t < 300 && !bus.cpu_rd_ready; t++) @(negedge clk);
    ok = bus.cpu_rd_ready;
    if (!ok) chk("rd_ready_timeout", 0, 1);
  endtask

  task automatic cpu_read(input logic [4:0] a);
    bit ok;
    wait_rd_ready(ok);
    if (ok) begin
      bus.cpu_rd_req = 1'b1;
      bus.cpu_rd_addr = a;
      exp_rd.push_back(ref_mem[a]);
      @(posedge clk);
      @(negedge clk);
      bus.cpu_rd_req = 1'b0;
    end
  endtask

  task automatic cpu_wr_rd(input logic [4:0] wa, input logic [15:0] wd, input logic [4:0] ra);
    bit ok, acc;
    wait_rd_ready(ok);
    if (ok) begin
      bus.cpu_rd_req = 1'b1;
      bus.cpu_rd_addr = ra;
      bus.cpu_wr_req = 1'b1;
      bus.cpu_wr_addr = wa;
      bus.cpu_wr_data = wd;
      acc = bus.cpu_wr_ready;
      @(posedge clk);
      if (acc) model_write(wa, wd);
      exp_rd.push_back(ref_mem[ra]);
      @(negedge clk);
      bus.cpu_rd_req = 1'b0;
      bus.cpu_wr_req = 1'b0;
      chk("same_cycle_wr_accepted", 32'(acc), 1);
    end
  endtask

  task automatic wait_rd_done(output int steps);
    logic pd;
    steps = 0;
    pd = 1'b0;
    while (!bus.cpu_rd_done && steps < 200) begin
      pd = bus.mem_done;
      @(negedge clk);
      steps++;
    end
    md_before_done = pd;
    if (!bus.cpu_rd_done) chk("rd_done_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 400 && (exp_wr.size() != 0 || exp_rd.size() != 0); t++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("drain_complete", 32'(exp_wr.size()), 0);
    chk("reads_complete", 32'(exp_rd.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cpu_wr_req = 1'b0; bus.cpu_wr_addr = '0; bus.cpu_wr_data = '0;
    bus.cpu_rd_req = 1'b0; bus.cpu_rd_addr = '0;
    for (int a = 0; a < 32; a++) ref_mem[a] = init_val(a);
    repeat (3) @(negedge clk);
    chk("reset_memread", 32'(bus.mem_memread), 0);
    chk("reset_memwrite", 32'(bus.mem_memwrite), 0);
    chk("reset_rd_done", 32'(bus.cpu_rd_done), 0);
    chk("reset_mem_addr", 32'(bus.mem_addr), 0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("post_reset_wr_ready", 32'(bus.cpu_wr_ready), 1);
    chk("post_reset_rd_ready", 32'(bus.cpu_rd_ready), 1);
    // single write drains once
    base = n_memwrite;
    cpu_write(5'd3, 16'h1234);
    wait_idle();
    chk("single_drain_count", 32'(n_memwrite - base), 1);
    chk("single_mem_addr", 32'(bus.mem_addr), 3);
    chk("single_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
    chk("single_wr_ready", 32'(bus.cpu_wr_ready), 1);
    // fill while a read is stalled
    stall = 1'b1; mem_wait = 0;
    cpu_read(5'd20);
    for (int i = 0; i < 4; i++) cpu_write(5'(i), 16'hA000 + 16'(i));
    chk("full_wr_ready", 32'(bus.cpu_wr_ready), 0);
    base = n_memwrite;
    fork
      cpu_write(5'd4, 16'hA004);
      begin
        repeat (5) @(negedge clk);
        chk("full_hold_wr_ready", 32'(bus.cpu_wr_ready), 0);
        chk("no_drain_while_reading", 32'(n_memwrite - base), 0);
        stall = 1'b0;
      end
    join
    chk("fifth_after_first_pop", 32'(acc_memwrites - base), 1);
    wait_idle();
    chk("fill_drain_count", 32'(n_memwrite - base), 5);
    // coalesce then forward
    stall = 1'b1;
    cpu_read(5'd21);
    cpu_write(5'd7, 16'hAAAA);
    cpu_write(5'd7, 16'hBBBB);
    base = n_memwrite;
    stall = 1'b0;
    wait_rd_done(st);
    base_rd = n_memread;
    cpu_read(5'd7);
    chk("hit_done_next_cycle", 32'(bus.cpu_rd_done), 1);
    chk("hit_no_memread", 32'(bus.mem_memread), 0);
    wait_idle();
    chk("hit_memread_count", 32'(n_memread - base_rd), 0);
    chk("coalesced_drain_count", 32'(n_memwrite - base), 1);
    // read miss beats pending drain
    mem_wait = 9; stall = 1'b1;
    cpu_read(5'd22);
    cpu_write(5'd2, 16'h2222);
    stall = 1'b0;
    wait_rd_done(st);
    base = n_memwrite;
    cpu_read(5'd9);
    chk("miss_memread", 32'(bus.mem_memread), 1);
    chk("miss_mem_addr", 32'(bus.mem_addr), 9);
    chk("miss_before_drain", 32'(n_memwrite - base), 0);
    wait_rd_done(st);
    chk("miss_latency", 32'(st), 10);
    chk("miss_done_after_mem_done", 32'(md_before_done), 1);
    wait_idle();
    chk("miss_then_drain", 32'(n_memwrite - base), 1);
    // same-cycle write and read forward
    base_rd = n_memread;
    cpu_wr_rd(5'd5, 16'h5555, 5'd5);
    chk("fwd_done", 32'(bus.cpu_rd_done), 1);
    chk("fwd_no_memread", 32'(bus.mem_memread), 0);
    wait_idle();
    chk("fwd_memread_count", 32'(n_memread - base_rd), 0);
    // mixed traffic
    mem_wait = 2;
    for (int i = 0; i < 8; i++) begin
      cpu_write(5'(12 + i), 16'($urandom));
      cpu_read(5'($urandom_range(0, 31)));
    end
    wait_idle();
    // reset mid-read discards in-flight state
    stall = 1'b1;
    cpu_read(5'd10);
    cpu_write(5'd11, 16'h1111);
    chk("pre_reset_memread", 32'(bus.mem_memread), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_memread_drop", 32'(bus.mem_memread), 0);
    chk("async_memwrite_low", 32'(bus.mem_memwrite), 0);
    exp_rd.delete();
    exp_wr.delete();
    for (int a = 0; a < 32; a++) ref_mem[a] = init_val(a);
    stall = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    base = n_memwrite;
    @(negedge clk);
    chk("rst2_wr_ready", 32'(bus.cpu_wr_ready), 1);
    chk("rst2_rd_ready", 32'(bus.cpu_rd_ready), 1);
    repeat (8) @(negedge clk);
    chk("rst2_no_drain", 32'(n_memwrite - base), 0);
    cpu_read(5'd11);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
- Posted-write buffer between the cache controller and the 32-word x 16-bit main memory. Sits directly upstream of the memory.
- Absorbs cache write-backs so the controller never stalls on memory writes. Drains them to memory when the memory port is idle.
- Services cache read misses with priority over draining. Forwards data for reads that hit a buffered write.

Parameters:
- DEPTH, 4, number of buffered write entries (power of two, at least 2)
- ADDR_W, 5, word address width
- DATA_W, 16, data width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous assert, active-low
- cpu_wr_req  in  1  post a write (addr/data valid this cycle)
- cpu_wr_addr  in  ADDR_W  write word address
- cpu_wr_data  in  DATA_W  write data
- cpu_wr_ready  out  1  buffer can accept a write this cycle
- cpu_rd_req  in  1  one-cycle read request; honoured only when cpu_rd_ready=1
- cpu_rd_addr  in  ADDR_W  read word address
- cpu_rd_ready  out  1  read port idle
- cpu_rd_data  out  DATA_W  read result, valid while cpu_rd_done=1
- cpu_rd_done  out  1  one-cycle read completion pulse
- mem_addr  out  ADDR_W  memory word address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_memread  out  1  memory read strobe, held until mem_done
- mem_memwrite  out  1  memory write strobe, one cycle per entry
- mem_rdata  in  DATA_W  memory read data, valid when mem_done=1
- mem_done  in  1  memory completion; asserted in the same cycle as mem_memwrite

Behaviour:
- Reset (rst=0, asynchronous):
  - count, head and tail pointers cleared; state=IDLE.
  - All outputs 0, except cpu_wr_ready=1 and cpu_rd_ready=1 once reset releases.
  - mem_memread and mem_memwrite drop immediately, even mid-read or mid-drain. In-flight data is discarded.
- Storage: circular FIFO of {addr,data} entries; count ranges 0..DEPTH.
- cpu_wr_ready = (count != DEPTH). It is combinational from the registered count. A pop in the same cycle does not raise it.
- Write accept (cpu_wr_req & cpu_wr_ready):
  - If a valid entry has the same addr and is not the entry being issued this cycle, overwrite its data in place (coalesce); count is unchanged.
  - Otherwise append at the tail.
  - Addresses in the buffer are therefore unique, except for the entry in flight.
- cpu_wr_req while full: ignored, no state change. The requester must hold the write until ready.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE, cpu_rd_req=1:
    - Hit: address matches a buffer entry, or a same-cycle accepted write (that write takes precedence). Go to RESP with the forwarded data latched. No memory access.
    - Miss: load mem_addr; mem_memread=1 from the next cycle; go to READ.
  - IDLE, no read and count>0: load mem_addr/mem_wdata from the head; go to WRITE.
  - IDLE, otherwise: stay.
  - READ: hold mem_memread and mem_addr stable. On mem_done=1, latch mem_rdata, drop mem_memread, go to RESP. No cycle limit.
  - WRITE: mem_memwrite=1 for exactly one cycle. Pop the head at the end of the cycle. Return to IDLE, which re-arbitrates, so a pending read takes priority over the next drain.
  - RESP: cpu_rd_done=1 for one cycle with cpu_rd_data; return to IDLE.
- cpu_rd_ready = (state==IDLE). A cpu_rd_req when not ready is ignored.
- Latency:
  - Read hit: request cycle + 1 = done.
  - Read miss: memory latency + 2.
  - Drain: 2 cycles per entry (IDLE issue + WRITE) when no reads compete.
- Simultaneous push and pop: both take effect; count unchanged.

Test Plan:
- Reset mid-read: assert rst=0 while mem_memread=1 -> mem_memread=0 in the same cycle. After release: count=0, cpu_rd_ready=1, cpu_wr_ready=1.
- Write 0x1234 to addr 3, then no reads -> mem_memwrite pulses once with mem_addr=3, mem_wdata=0x1234; count returns to 0.
- Fill 4 writes (addr 0..3) with the memory read stalled in READ -> cpu_wr_ready=0 after the 4th. A 5th write is ignored until the first pop; order is preserved on drain.
- Write 0xAAAA then 0xBBBB to addr 7 while blocked -> count=1. A read of addr 7 returns 0xBBBB with cpu_rd_done one cycle after the request, with no mem_memread.
- Buffer holds addr 2; read addr 9 (miss) -> mem_memread on addr 9 is issued before any memwrite. Memory returns 0x0908 after 9 wait states -> cpu_rd_done with 0x0908 the cycle after mem_done; the drain of addr 2 follows.
- Same-cycle write (addr 5, 0x5555) and read (addr 5) in IDLE -> forwarded 0x5555; no memory read.
